// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD digit type, limits, countdown states and clamp helper
package bcd_pkg;
   typedef logic [3:0] bcd_digit_t;
   localparam bcd_digit_t BCD_MAX  = 4'd9;
   localparam bcd_digit_t BCD_ZERO = 4'd0;
   typedef enum logic {IDLE, RUN} bcd_dn_state_t;
   function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
      return (d > BCD_MAX) ? BCD_MAX : d;
   endfunction
endpackage

// File: rtl/bcd_down_counter_if.sv
// bcd_down_counter_if: control and count bus of the BCD countdown timer
interface bcd_down_counter_if #(parameter int DIGITS = 4);
   logic                  load;
   logic [4*DIGITS-1:0]   load_value;
   logic                  start;
   logic                  stop;
   logic                  enable;
   logic [4*DIGITS-1:0]   Q;
   logic                  busy;
   logic                  zero;
   logic                  done;
   modport master(output load, load_value, start, stop, enable, input Q, busy, zero, done);
   modport slave(input load, load_value, start, stop, enable, output Q, busy, zero, done);
endinterface

// File: rtl/bcd_down_digit.sv
// bcd_down_digit: one BCD digit of the borrow-ripple decrementer
module bcd_down_digit
   import bcd_pkg::*;
(
   input  bcd_digit_t digit_in,
   input  logic       borrow_in,
   output bcd_digit_t digit_out,
   output logic       borrow_out
);
   assign borrow_out = borrow_in && (digit_in == BCD_ZERO);
   assign digit_out  = !borrow_in ? digit_in : borrow_out ? BCD_MAX : digit_in - 4'd1;
endmodule

// File: rtl/bcd_down_counter.sv
// bcd_down_counter: multi-digit BCD countdown timer; BCD_DOWN_AUTO_RELOAD_EN restarts from the loaded value
module bcd_down_counter
   import bcd_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input logic               clk,
   input logic               reset_n,
   bcd_down_counter_if.slave bus
);
   localparam int W = 4*DIGITS;
   bcd_dn_state_t   state_q;
   logic [W-1:0]    q_q;
   logic            done_q;
   logic [W-1:0]    clamp_d;
   logic [W-1:0]    dec_d;
   logic [DIGITS:0] borrow;
`ifdef BCD_DOWN_AUTO_RELOAD_EN
   logic [W-1:0]    reload_q;
`endif
   assign borrow[0] = 1'b1;
   for (genvar i = 0; i < DIGITS; i++) begin : g_dig
      assign clamp_d[4*i +: 4] = bcd_clamp(bus.load_value[4*i +: 4]);
      bcd_down_digit u_dig (
         .digit_in  (q_q[4*i +: 4]),
         .borrow_in (borrow[i]),
         .digit_out (dec_d[4*i +: 4]),
         .borrow_out(borrow[i+1])
      );
   end
   assign bus.Q    = q_q;
   assign bus.busy = (state_q == RUN);
   assign bus.zero = borrow[DIGITS];
   assign bus.done = done_q;
   // Countdown FSM: load > stop > start > enable; done pulses on the completing edge only
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         q_q     <= '0;
         done_q  <= 1'b0;
`ifdef BCD_DOWN_AUTO_RELOAD_EN
         reload_q <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         if (bus.load) begin
            q_q     <= clamp_d;
            state_q <= IDLE;
`ifdef BCD_DOWN_AUTO_RELOAD_EN
            reload_q <= clamp_d;
`endif
         end else if (state_q == RUN) begin
            if (bus.stop) begin
               state_q <= IDLE;
            end else if (bus.enable) begin
               q_q <= dec_d;
               if (q_q == W'(1)) begin
                  done_q  <= 1'b1;
                  state_q <= IDLE;
`ifdef BCD_DOWN_AUTO_RELOAD_EN
                  if (reload_q != '0) begin
                     q_q     <= reload_q;
                     state_q <= RUN;
                  end
`endif
               end
            end
         end else if (bus.start) begin
            if (bus.zero) done_q <= 1'b1;
            else state_q <= RUN;
         end
      end
   end
endmodule

// File: doc/bcd_down_counter.md
Name: bcd_down_counter

Overview:
- Multi-digit BCD down-counter (countdown timer), the decrementing counterpart of the team's BCD up-counter.
- Loaded with a packed BCD value and started. It decrements once per enable tick, with borrow rippling across digits.
- At zero it pulses done and returns to idle.
- Used for timeout and countdown displays that drive BCD 7-segment decoders directly.

Parameters:
- DIGITS, 4, number of BCD digits; Q width is 4*DIGITS.

Ports:
- clk  input  1  clock
- reset_n  input  1  reset
- load  input  1  load load_value into Q; forces IDLE
- load_value  input  4*DIGITS  packed BCD value; digit 0 in bits [3:0]
- start  input  1  begin countdown from current Q
- stop  input  1  abort countdown; Q holds
- enable  input  1  decrement tick, qualified in RUN only
- Q  output  4*DIGITS  current count, packed BCD, registered
- busy  output  1  high while in RUN
- zero  output  1  combinational, Q == 0
- done  output  1  one-cycle registered pulse when the countdown completes

Interface decision:
- Reset reset_n, asynchronous, active-low; clock clk.

Behaviour:
- Reset: Q = 0, state = IDLE, busy = 0, done = 0. zero is therefore 1.
- States: IDLE, RUN. busy = (state == RUN).
- Priority per cycle: load > stop > start > enable.
- load, any state:
  - Q <= load_value with each digit > 9 clamped to 9.
  - State -> IDLE; done = 0.
  - A start or enable in the same cycle is ignored.
- stop in RUN: state -> IDLE; Q holds; no done. stop in IDLE: no effect.
- start in IDLE:
  - If Q != 0: state -> RUN; the first decrement happens on the next enable cycle, not the start cycle.
  - If Q == 0: done pulses the next cycle; state stays IDLE.
- start in RUN: ignored.
- enable in RUN (BCD decrement):
  - Digit 0 always decrements.
  - A digit at 0 with borrow-in becomes 9 and propagates borrow.
  - A digit > 0 with borrow-in decrements and stops the borrow.
  - Q == 0 never occurs in RUN, so no wrap below zero.
- Completion: when Q is 1 and enable is high in RUN:
  - Q becomes 0, done = 1 and state -> IDLE, all on the same edge.
  - done drops the following cycle.
- enable low in RUN: Q holds. enable in IDLE: ignored.
- done is asserted for exactly one cycle per completed countdown, never during load or stop.
- Reset mid-RUN: immediate return to reset values; no done pulse.
- Latency: one cycle from an enable edge to the updated Q.

Optional Feature:
- Macro: BCD_DOWN_AUTO_RELOAD_EN.
- Defined:
  - load also captures the clamped value into a reload register.
  - At completion, Q <= reload value instead of 0, done still pulses, and state remains RUN.
  - If the reload value is 0, behaviour is as without the macro.
  - stop and load still force IDLE.
- Undefined: no reload register; completion always ends in IDLE with Q = 0.

Decomposition:
- Shared package bcd_pkg holds:
  - bcd_digit_t, a 4-bit typedef
  - BCD_MAX = 9 and BCD_ZERO = 0
  - state enum bcd_dn_state_t {IDLE, RUN}
  - clamp function bcd_clamp
- One sub-module, bcd_down_digit:
  - Combinational, one per digit via generate.
  - Inputs: digit_in, borrow_in. Outputs: digit_out, borrow_out.
- Top level holds the state register, Q register, done register and priority logic.

Test Plan:
1. Reset asserted mid-RUN at Q=0x0050 -> Q=0x0000, busy=0, done=0, zero=1 immediately; no done after release.
2. load 0x0102, start, enable every cycle -> Q: 0101, 0100, 0099, 0098, …; Q=0x0000 after the 102nd enable with a 1-cycle done pulse; busy falls on the same edge.
3. load 0x00A5 -> Q=0x0095 (clamp); load 0xFFFF -> Q=0x9999.
4. start with Q=0x0000 -> done=1 on the next cycle only; busy stays 0.
5. In RUN at Q=0x0050, assert stop -> Q holds 0x0050, busy=0, no done. Then start plus 50 enables -> done pulse and Q=0x0000.
6. In RUN, load=1 with enable=1 and start=1, load_value=0x0007 -> Q=0x0007, state IDLE, no decrement. With BCD_DOWN_AUTO_RELOAD_EN: load 0x0003, start, 3 enables -> done pulses, Q=0x0003, busy stays 1.
